dmem_access_responder: RTL
==========================

Name: dmem_access_responder

Overview:
- Responder side of the memory-access-stage data interface.
- Accepts one load or store request at a time from the memory access stage: address, width code (00 byte, 01 half, 10 word), unsigned flag and write data.
- Drives a word-wide synchronous single-port data SRAM with byte enables.
- Returns lane-extracted, sign/zero-extended load data, or a store completion, through a valid/ready handshake, with configurable wait states.

Parameters:
- ADDR_W, 14, word-address width of the SRAM (capacity 4·2^ADDR_W bytes); byte-address bits above ADDR_W+1 are ignored.
- WAIT_CYCLES, 0, extra cycles inserted between the SRAM access and the response (0..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder idle, request accepted when req_valid&&req_ready
- req_addr  in  32  byte address
- req_is_load  in  1  load request
- req_is_store  in  1  store request
- req_width  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  zero-extend loads when 1
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data (0 for store/error)
- resp_error  out  1  misaligned/illegal request, qualified by resp_valid
- mem_en  out  1  SRAM access strobe
- mem_we  out  4  SRAM byte write enables
- mem_addr  out  ADDR_W  SRAM word address = req_addr[ADDR_W+1:2]
- mem_wdata  out  32  lane-steered write data
- mem_rdata  in  32  SRAM read data, valid the cycle after mem_en

Behaviour:
- Reset (synchronous, active-high): state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation drops any in-flight request: no response, no SRAM write after the reset edge.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE: req_ready=1. On accept in cycle T, the request is registered.
  - Legal request: go to ACCESS.
  - Error request: go directly to RESP with resp_error=1.
  - No-op (neither load nor store): go to RESP with resp_error=0 and rdata=0.
- ACCESS (T+1): mem_en=1.
  - Store: mem_we = lane mask.
  - Load: mem_we=0.
  - Next state is WAIT if WAIT_CYCLES>0, else RESP.
- WAIT: counter loads WAIT_CYCLES−1 on entry, decrements each cycle, leaves for RESP when it reaches 0. Load data is captured from mem_rdata in the cycle after ACCESS, before or at WAIT entry.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata/resp_error hold their values until the next response.
- Latency:
  - Legal load/store: resp_valid at T+2+WAIT_CYCLES.
  - Error/no-op: resp_valid at T+1.
  - Throughput: one request per 3+WAIT_CYCLES cycles.
- req_ready is 0 in ACCESS/WAIT/RESP. Request inputs are ignored there and need not be held after acceptance.
- Error conditions:
  - req_width=11.
  - Half with addr[0]=1.
  - Word with addr[1:0]≠0.
  - req_is_load and req_is_store both set.
  - On error, no SRAM access occurs.
- Store lane steering:
  - byte: mem_we = 0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - half: mem_we = addr[1]?1100:0011, wdata = {2{wdata[15:0]}}.
  - word: mem_we = 1111, wdata unchanged.
- Load extraction:
  - byte: mem_rdata[8·addr[1:0]+:8].
  - half: mem_rdata[16·addr[1]+:16].
  - Sign-extended unless req_unsigned. Word loads ignore req_unsigned.
- mem_we is nonzero only in an ACCESS cycle of a store. mem_en is 0 outside ACCESS.

Test Plan:
- Reset, then word store addr 0x100 data 0xDEADBEEF, WAIT_CYCLES=0 → mem_en/mem_we=1111 at T+1, mem_addr=0x40; resp_valid at T+2, resp_error=0, resp_rdata=0.
- Preload word 0x40 = 0x80FF7F01; byte loads at 0x101 and 0x103, signed → rdata 0x0000007F and 0xFFFFFF80; unsigned byte at 0x102 → 0x000000FF; signed half at 0x102 → 0xFFFF80FF.
- Half store addr 0x102 data 0x1234 → mem_we=1100, mem_wdata=0x12341234; word reload → 0x12347F01.
- Misaligned word load 0x101, half store 0x103, width 11 → resp_valid at T+1, resp_error=1, mem_en never asserted.
- WAIT_CYCLES=3 word load → resp_valid at T+5; req_ready low T+1..T+5; a req_valid held high is accepted only at T+6.
- Assert rst during WAIT of a load → no resp_valid, state IDLE, req_ready=1 the cycle after reset deasserts, all outputs at reset values.

Source files
------------

// File: rtl/dmem_access_responder_if.sv
// Request/response bundle between the memory access stage (master) and the
// data-memory responder (slave).
//   req_valid/req_ready : request handshake, accepted when both high
//   req_addr            : byte address
//   req_is_load/store   : access kind (neither = no-op, both = error)
//   req_width           : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned        : zero-extend sub-word loads
//   req_wdata           : right-aligned store data
//   resp_valid          : one-cycle response pulse
//   resp_rdata          : extended load data (0 for store/error/no-op)
//   resp_error          : misaligned/illegal request flag
interface dmem_access_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_is_load;
  logic        req_is_store;
  logic [1:0]  req_width;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_addr, req_is_load, req_is_store, req_width,
           req_unsigned, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_addr, req_is_load, req_is_store, req_width,
           req_unsigned, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/dmem_access_responder.sv
// Data-memory responder: accepts one load/store at a time, drives a
// word-wide synchronous SRAM with byte enables, and returns extended load
// data or a store completion after WAIT_CYCLES extra wait states.
//   clk, rst  : clock, synchronous active-high reset
//   dmem      : request/response bundle (slave side)
//   mem_en    : SRAM access strobe (ACCESS state only)
//   mem_we    : SRAM byte write enables
//   mem_addr  : SRAM word address
//   mem_wdata : lane-steered write data
//   mem_rdata : SRAM read data, valid the cycle after mem_en
module dmem_access_responder #(
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  dmem_access_responder_if.slave dmem,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : '0;

  state_t          state, state_nx;
  logic [ADDR_W+1:0] addr_r;
  logic [31:0]     wdata_r;
  logic [1:0]      width_r;
  logic            uns_r, load_r, store_r, err_r, legal_r;
  logic [3:0]      cnt;
  logic            cap;
  logic [31:0]     load_data, resp_rdata_r;
  logic            resp_error_r;

  logic            accept, req_err, req_legal;
  logic [3:0]      lane_mask;
  logic [31:0]     shifted, extracted, data_now, rdata_now;

  assign accept = dmem.req_valid && (state == IDLE);

  always_comb begin
    req_err = 1'b0;
    if (dmem.req_width == 2'b11) req_err = 1'b1;
    if (dmem.req_width == 2'b01 && dmem.req_addr[0]) req_err = 1'b1;
    if (dmem.req_width == 2'b10 && dmem.req_addr[1:0] != 2'b00) req_err = 1'b1;
    if (dmem.req_is_load && dmem.req_is_store) req_err = 1'b1;
    req_legal = !req_err && (dmem.req_is_load || dmem.req_is_store);
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = req_legal ? ACCESS : RESP;
      ACCESS:  state_nx = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT:    if (cnt == '0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      addr_r       <= '0;
      wdata_r      <= '0;
      width_r      <= '0;
      uns_r        <= 1'b0;
      load_r       <= 1'b0;
      store_r      <= 1'b0;
      err_r        <= 1'b0;
      legal_r      <= 1'b0;
      cnt          <= '0;
      cap          <= 1'b0;
      load_data    <= '0;
      resp_rdata_r <= '0;
      resp_error_r <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        addr_r  <= dmem.req_addr[ADDR_W+1:0];
        wdata_r <= dmem.req_wdata;
        width_r <= dmem.req_width;
        uns_r   <= dmem.req_unsigned;
        load_r  <= req_legal && dmem.req_is_load;
        store_r <= req_legal && dmem.req_is_store;
        err_r   <= req_err;
        legal_r <= req_legal;
      end
      // SRAM data arrives the cycle after ACCESS; keep it for late responses.
      cap <= (state == ACCESS);
      if (cap) load_data <= extracted;
      if (state_nx == WAIT && state != WAIT) cnt <= WAIT_INIT;
      else if (state == WAIT) cnt <= cnt - 4'd1;
      // Response values are latched at RESP so they hold until the next one.
      if (state == RESP) begin
        resp_rdata_r <= rdata_now;
        resp_error_r <= err_r;
      end
    end
  end

  always_comb begin
    case (width_r)
      2'b00:   lane_mask = 4'b0001 << addr_r[1:0];
      2'b01:   lane_mask = addr_r[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  end

  always_comb begin
    case (width_r)
      2'b00:   mem_wdata = {4{wdata_r[7:0]}};
      2'b01:   mem_wdata = {2{wdata_r[15:0]}};
      default: mem_wdata = wdata_r;
    endcase
  end

  // Half accesses are aligned, so the byte shift also selects the half lane.
  assign shifted = mem_rdata >> {addr_r[1:0], 3'b000};

  always_comb begin
    extracted = '0;
    if (load_r) begin
      case (width_r)
        2'b00:   extracted = uns_r ? {24'b0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
        2'b01:   extracted = uns_r ? {16'b0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
        default: extracted = mem_rdata;
      endcase
    end
  end

  assign data_now  = cap ? extracted : load_data;
  assign rdata_now = legal_r ? data_now : '0;

  assign mem_en   = (state == ACCESS);
  assign mem_we   = (state == ACCESS && store_r) ? lane_mask : '0;
  assign mem_addr = addr_r[ADDR_W+1:2];

  assign dmem.req_ready  = (state == IDLE);
  assign dmem.resp_valid = (state == RESP);
  assign dmem.resp_rdata = (state == RESP) ? rdata_now : resp_rdata_r;
  assign dmem.resp_error = (state == RESP) ? err_r : resp_error_r;

endmodule
